spi_slv: RTL and testbench

//  SPI peripheral (slave) endpoint: the far end of the SPI master link. Samples external sck/cs_n/mosi,

---
 rtl/spi_pkg.sv | 24 ++
 rtl/sync_fifo.sv | 59 +++++
 rtl/spi_slv.sv | 197 +++++++++++++++++++
 tb/tb_spi_slv.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: register map, STATUS/CTRL bit positions and frame state shared by spi_slv.
package spi_pkg;

    localparam logic [4:0] ADDR_RXDATA = 5'h00;
    localparam logic [4:0] ADDR_TXDATA = 5'h04;
    localparam logic [4:0] ADDR_STATUS = 5'h08;
    localparam logic [4:0] ADDR_CTRL   = 5'h0C;

    localparam int STAT_RX_EMPTY = 0;
    localparam int STAT_RX_FULL  = 1;
    localparam int STAT_TX_EMPTY = 2;
    localparam int STAT_TX_FULL  = 3;
    localparam int STAT_RX_OVR   = 4;
    localparam int STAT_TX_OVF   = 5;

    localparam int CTRL_FLUSH  = 0;
    localparam int CTRL_IRQ_EN = 1;

    typedef enum logic {
        FRAME_IDLE,
        FRAME_ACTIVE
    } frame_state_e;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock show-ahead FIFO with flush; a push succeeds when full if a pop happens the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    // NOTE: the storage array has no reset; only pointers and count need a defined state.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/spi_slv.sv
// spi_slv: SPI mode-0 slave with RX/TX FIFOs behind the handshake register interface.
// Optional interrupt output and CTRL.irq_en are built only when SPI_SLV_IRQ_EN is defined.
module spi_slv
    import spi_pkg::*;
#(
    parameter int         FIFO_DEPTH = 8,
    parameter logic [7:0] FILL_BYTE  = 8'hFF
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       hs_read_i,
    input  logic       hs_write_i,
    input  logic [4:0] hs_addr_i,
    input  logic [7:0] hs_data_i,
    output logic       hs_ready_o,
    output logic [7:0] hs_data_o,
    input  logic       sck_i,
    input  logic       cs_ni,
    input  logic       mosi_i,
    output logic       miso_o,
    output logic       miso_oe_o
`ifdef SPI_SLV_IRQ_EN
    ,
    output logic       irq_o
`endif
);

    logic cs_meta, cs_s, cs_d;
    logic sck_meta, sck_s, sck_d;
    logic mosi_meta, mosi_s;

    // NOTE: registers use non-blocking assignments so every stage samples the previous cycle's value.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cs_meta   <= 1'b1;
            cs_s      <= 1'b1;
            cs_d      <= 1'b1;
            sck_meta  <= 1'b0;
            sck_s     <= 1'b0;
            sck_d     <= 1'b0;
            mosi_meta <= 1'b0;
            mosi_s    <= 1'b0;
        end else begin
            cs_meta   <= cs_ni;
            cs_s      <= cs_meta;
            cs_d      <= cs_s;
            sck_meta  <= sck_i;
            sck_s     <= sck_meta;
            sck_d     <= sck_s;
            mosi_meta <= mosi_i;
            mosi_s    <= mosi_meta;
        end
    end

    frame_state_e state;
    logic [2:0]   bit_cnt;
    logic [6:0]   rx_sh;
    logic [6:0]   tx_rest;
    logic         cs_fall, cs_rise, sck_rise, sck_fall, spi_step;
    logic         rx_push, rx_pop, rx_full, rx_empty;
    logic         tx_load, tx_push, tx_full, tx_empty;
    logic [7:0]   rx_rdata, tx_rdata, tx_byte, rx_byte;
    logic         rx_ovr, tx_ovf, flush;

    assign cs_fall  = cs_d & ~cs_s;
    assign cs_rise  = ~cs_d & cs_s;
    assign sck_rise = ~sck_d & sck_s;
    assign sck_fall = sck_d & ~sck_s;
    assign spi_step = (state == FRAME_ACTIVE) & ~cs_rise & ~cs_fall;
    assign rx_byte  = {rx_sh, mosi_s};
    assign rx_push  = spi_step & sck_rise & (bit_cnt == 3'd7);
    assign tx_load  = cs_fall | (spi_step & sck_fall & (bit_cnt == 3'd0));
    assign tx_byte  = tx_empty ? FILL_BYTE : tx_rdata;

    // miso_o holds the bit on the wire; tx_rest holds the bits still to come.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= FRAME_IDLE;
            bit_cnt   <= '0;
            rx_sh     <= '0;
            tx_rest   <= '0;
            miso_o    <= 1'b0;
            miso_oe_o <= 1'b0;
        end else if (cs_rise) begin
            state     <= FRAME_IDLE;
            bit_cnt   <= '0;
            miso_o    <= 1'b0;
            miso_oe_o <= 1'b0;
        end else if (cs_fall) begin
            state     <= FRAME_ACTIVE;
            bit_cnt   <= '0;
            miso_o    <= tx_byte[7];
            tx_rest   <= tx_byte[6:0];
            miso_oe_o <= 1'b1;
        end else if (spi_step) begin
            if (sck_rise) begin
                rx_sh   <= rx_byte[6:0];
                bit_cnt <= bit_cnt + 3'd1;
            end else if (sck_fall) begin
                if (bit_cnt != 3'd0) begin
                    miso_o  <= tx_rest[6];
                    tx_rest <= {tx_rest[5:0], 1'b0};
                end else begin
                    miso_o  <= tx_byte[7];
                    tx_rest <= tx_byte[6:0];
                end
            end
        end
    end

    logic       req, wr_en, rd_en, ctrl_wr, stat_wr;
    logic [7:0] status, rd_val;
    logic       irq_en;

    assign req     = (hs_read_i | hs_write_i) & ~hs_ready_o;
    assign wr_en   = req & hs_write_i;
    assign rd_en   = req & ~hs_write_i;
    assign ctrl_wr = wr_en & (hs_addr_i == ADDR_CTRL);
    assign stat_wr = wr_en & (hs_addr_i == ADDR_STATUS);
    assign flush   = ctrl_wr & hs_data_i[CTRL_FLUSH];
    assign tx_push = wr_en & (hs_addr_i == ADDR_TXDATA);
    assign rx_pop  = rd_en & (hs_addr_i == ADDR_RXDATA);

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        status                = '0;
        status[STAT_RX_EMPTY] = rx_empty;
        status[STAT_RX_FULL]  = rx_full;
        status[STAT_TX_EMPTY] = tx_empty;
        status[STAT_TX_FULL]  = tx_full;
        status[STAT_RX_OVR]   = rx_ovr;
        status[STAT_TX_OVF]   = tx_ovf;
        rd_val                = '0;
        if (rd_en) begin
            case (hs_addr_i)
                ADDR_RXDATA: rd_val = rx_empty ? 8'h00 : rx_rdata;
                ADDR_STATUS: rd_val = status;
                ADDR_CTRL:   rd_val[CTRL_IRQ_EN] = irq_en;
                default:     rd_val = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hs_ready_o <= 1'b0;
            hs_data_o  <= '0;
            rx_ovr     <= 1'b0;
            tx_ovf     <= 1'b0;
        end else begin
            hs_ready_o <= req;
            hs_data_o  <= rd_val;
            // A new overflow in the same cycle as a clear wins, so no event is lost.
            rx_ovr <= (rx_push & rx_full & ~rx_pop) | (rx_ovr & ~(stat_wr & hs_data_i[STAT_RX_OVR]));
            tx_ovf <= (tx_push & tx_full & ~tx_load) | (tx_ovf & ~(stat_wr & hs_data_i[STAT_TX_OVF]));
        end
    end

`ifdef SPI_SLV_IRQ_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            irq_en <= 1'b0;
            irq_o  <= 1'b0;
        end else begin
            if (ctrl_wr) irq_en <= hs_data_i[CTRL_IRQ_EN];
            irq_o <= irq_en & (~rx_empty | rx_ovr | tx_ovf);
        end
    end
`else
    assign irq_en = 1'b0;
`endif

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push   (rx_push),
        .pop    (rx_pop),
        .flush  (flush),
        .wdata  (rx_byte),
        .rdata  (rx_rdata),
        .full   (rx_full),
        .empty  (rx_empty)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push   (tx_push),
        .pop    (tx_load),
        .flush  (flush),
        .wdata  (hs_data_i),
        .rdata  (tx_rdata),
        .full   (tx_full),
        .empty  (tx_empty)
    );

endmodule

// File: tb/tb_spi_slv.sv
// tb_spi_slv: register-map vector table, directed SPI corner cases and a randomized run against a queue model.
module tb_spi_slv;
    import spi_pkg::*;

    localparam int DEPTH = 8;
    localparam int H     = 6;

    logic       clk_i      = 1'b0;
    logic       rst_ni     = 1'b0;
    logic       hs_read_i  = 1'b0;
    logic       hs_write_i = 1'b0;
    logic [4:0] hs_addr_i  = '0;
    logic [7:0] hs_data_i  = '0;
    logic       hs_ready_o;
    logic [7:0] hs_data_o;
    logic       sck_i      = 1'b0;
    logic       cs_ni      = 1'b1;
    logic       mosi_i     = 1'b0;
    logic       miso_o;
    logic       miso_oe_o;
`ifdef SPI_SLV_IRQ_EN
    logic       irq_o;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    spi_slv #(.FIFO_DEPTH(DEPTH), .FILL_BYTE(8'hFF)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .hs_read_i  (hs_read_i),
        .hs_write_i (hs_write_i),
        .hs_addr_i  (hs_addr_i),
        .hs_data_i  (hs_data_i),
        .hs_ready_o (hs_ready_o),
        .hs_data_o  (hs_data_o),
        .sck_i      (sck_i),
        .cs_ni      (cs_ni),
        .mosi_i     (mosi_i),
        .miso_o     (miso_o),
        .miso_oe_o  (miso_oe_o)
`ifdef SPI_SLV_IRQ_EN
        ,
        .irq_o      (irq_o)
`endif
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic       wr;
        logic [4:0] addr;
        logic [7:0] wd;
        logic [7:0] exp;
    } vec_t;

    vec_t       vecs[11];
    logic [7:0] mo[16];
    logic [7:0] mi[16];

    // Reference model: plain queues and sticky bits.
    logic [7:0] m_rx[$];
    logic [7:0] m_tx[$];
    logic       m_rx_ovr = 1'b0;
    logic       m_tx_ovf = 1'b0;

    function automatic logic [7:0] m_status();
        return {2'b00, m_tx_ovf, m_rx_ovr, (m_tx.size() == DEPTH), (m_tx.size() == 0),
                (m_rx.size() == DEPTH), (m_rx.size() == 0)};
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endtask

    task automatic bus(input logic wr, input logic [4:0] addr, input logic [7:0] wd, output logic [7:0] rd);
        int n = 0;
        @(negedge clk_i);
        hs_write_i = wr;
        hs_read_i  = ~wr;
        hs_addr_i  = addr;
        hs_data_i  = wd;
        do begin
            @(negedge clk_i);
            n++;
        end while (!hs_ready_o && n < 8);
        rd = hs_data_o;
        hs_write_i = 1'b0;
        hs_read_i  = 1'b0;
        check($sformatf("bus_latency_a%02h", addr), 8'(n), 8'd1);
    endtask

    task automatic reg_rd(input string name, input logic [4:0] addr, input logic [7:0] exp);
        logic [7:0] q;
        bus(1'b0, addr, 8'h00, q);
        check(name, q, exp);
    endtask

    task automatic reg_wr(input logic [4:0] addr, input logic [7:0] d);
        logic [7:0] q;
        bus(1'b1, addr, d, q);
    endtask

    task automatic spi_start();
        @(negedge clk_i);
        cs_ni = 1'b0;
        repeat (H) @(negedge clk_i);
        check("miso_oe_in_frame", 8'(miso_oe_o), 8'd1);
    endtask

    task automatic spi_end();
        repeat (H) @(negedge clk_i);
        cs_ni = 1'b1;
        repeat (H) @(negedge clk_i);
    endtask

    task automatic spi_byte(input logic [7:0] b, input int nbits, output logic [7:0] got);
        got = '0;
        for (int i = 7; i > 7 - nbits; i--) begin
            mosi_i = b[i];
            repeat (H) @(negedge clk_i);
            got[i] = miso_o;
            sck_i = 1'b1;
            repeat (H) @(negedge clk_i);
            sck_i = 1'b0;
        end
    endtask

    task automatic spi_frame(input int n);
        spi_start();
        for (int b = 0; b < n; b++) spi_byte(mo[b], 8, mi[b]);
        spi_end();
    endtask

    task automatic m_push_tx(input logic [7:0] d);
        reg_wr(ADDR_TXDATA, d);
        if (m_tx.size() < DEPTH) m_tx.push_back(d);
        else m_tx_ovf = 1'b1;
    endtask

    task automatic m_read_rx(input string name);
        logic [7:0] e;
        if (m_rx.size() != 0) e = m_rx.pop_front();
        else e = 8'h00;
        reg_rd(name, ADDR_RXDATA, e);
    endtask

    initial begin
        logic [7:0] q;
        int         n;
        int         k;
        logic [7:0] e;

        vecs[0]  = '{1'b0, ADDR_STATUS, 8'h00, 8'h05};
        vecs[1]  = '{1'b0, ADDR_RXDATA, 8'h00, 8'h00};
        vecs[2]  = '{1'b0, 5'h1C,       8'h00, 8'h00};
        vecs[3]  = '{1'b1, 5'h1C,       8'hFF, 8'h00};
        vecs[4]  = '{1'b0, ADDR_CTRL,   8'h00, 8'h00};
        vecs[5]  = '{1'b1, ADDR_TXDATA, 8'hA5, 8'h00};
        vecs[6]  = '{1'b1, ADDR_TXDATA, 8'h3C, 8'h00};
        vecs[7]  = '{1'b0, ADDR_STATUS, 8'h00, 8'h01};
        vecs[8]  = '{1'b0, ADDR_TXDATA, 8'h00, 8'h00};
        vecs[9]  = '{1'b1, ADDR_STATUS, 8'h30, 8'h00};
        vecs[10] = '{1'b0, ADDR_STATUS, 8'h00, 8'h01};

        #1;
        check("rst_hs_ready", 8'(hs_ready_o), 8'd0);
        check("rst_hs_data", hs_data_o, 8'h00);
        check("rst_miso", 8'(miso_o), 8'd0);
        check("rst_miso_oe", 8'(miso_oe_o), 8'd0);
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);

        for (int i = 0; i < 11; i++) begin
            bus(vecs[i].wr, vecs[i].addr, vecs[i].wd, q);
            if (!vecs[i].wr) check($sformatf("vec%0d", i), q, vecs[i].exp);
        end

        // Two-byte frame with A5/3C queued.
        mo[0] = 8'h81;
        mo[1] = 8'h7E;
        spi_frame(2);
        check("miso_byte0", mi[0], 8'hA5);
        check("miso_byte1", mi[1], 8'h3C);
        check("miso_oe_after", 8'(miso_oe_o), 8'd0);
        check("miso_after", 8'(miso_o), 8'd0);
        reg_rd("rx_byte0", ADDR_RXDATA, 8'h81);
        reg_rd("rx_byte1", ADDR_RXDATA, 8'h7E);
        reg_rd("status_idle", ADDR_STATUS, 8'h05);

        // TX empty: fill byte on miso.
        mo[0] = 8'h55;
        spi_frame(1);
        check("miso_fill", mi[0], 8'hFF);
        reg_rd("status_rx_one", ADDR_STATUS, 8'h04);
        reg_rd("rx_55", ADDR_RXDATA, 8'h55);

        // DEPTH+1 bytes without pops.
        for (int i = 0; i <= DEPTH; i++) mo[i] = 8'h10 + 8'(i);
        spi_frame(DEPTH + 1);
        reg_rd("status_ovr", ADDR_STATUS, 8'h16);
        for (int i = 0; i < DEPTH; i++) reg_rd($sformatf("rx_fill%0d", i), ADDR_RXDATA, 8'h10 + 8'(i));
        reg_rd("status_ovr_drained", ADDR_STATUS, 8'h15);
        reg_wr(ADDR_STATUS, 8'h10);
        reg_rd("status_ovr_cleared", ADDR_STATUS, 8'h05);

        // cs rises after 5 sck rises: partial byte discarded.
        spi_start();
        spi_byte(8'hE7, 5, q);
        spi_end();
        reg_rd("status_partial", ADDR_STATUS, 8'h05);
        reg_wr(ADDR_TXDATA, 8'h5A);
        mo[0] = 8'hC3;
        spi_frame(1);
        check("miso_after_partial", mi[0], 8'h5A);
        reg_rd("rx_after_partial", ADDR_RXDATA, 8'hC3);

        // Flush through CTRL.
        reg_wr(ADDR_TXDATA, 8'h11);
        reg_wr(ADDR_TXDATA, 8'h22);
        reg_wr(ADDR_TXDATA, 8'h33);
        mo[0] = 8'h99;
        spi_frame(1);
        check("miso_pre_flush", mi[0], 8'h11);
        reg_rd("status_pre_flush", ADDR_STATUS, 8'h00);
        reg_wr(ADDR_CTRL, 8'h01);
        reg_rd("status_flushed", ADDR_STATUS, 8'h05);
        reg_rd("rx_flushed", ADDR_RXDATA, 8'h00);

`ifdef SPI_SLV_IRQ_EN
        reg_wr(ADDR_CTRL, 8'h02);
        reg_rd("ctrl_irq_en", ADDR_CTRL, 8'h02);
        check("irq_idle", 8'(irq_o), 8'd0);
        mo[0] = 8'h42;
        spi_frame(1);
        check("irq_rx", 8'(irq_o), 8'd1);
        reg_rd("rx_irq", ADDR_RXDATA, 8'h42);
        repeat (2) @(negedge clk_i);
        check("irq_cleared", 8'(irq_o), 8'd0);
        reg_wr(ADDR_CTRL, 8'h00);
`else
        reg_wr(ADDR_CTRL, 8'h02);
        reg_rd("ctrl_no_irq", ADDR_CTRL, 8'h00);
`endif

        // Asynchronous reset in the middle of a byte.
        reg_wr(ADDR_TXDATA, 8'hFF);
        reg_wr(ADDR_TXDATA, 8'h77);
        spi_start();
        spi_byte(8'h0F, 4, q);
        check("miso_pre_reset", 8'(miso_o), 8'd1);
        rst_ni = 1'b0;
        #1;
        check("midrst_miso", 8'(miso_o), 8'd0);
        check("midrst_miso_oe", 8'(miso_oe_o), 8'd0);
        check("midrst_hs_ready", 8'(hs_ready_o), 8'd0);
        check("midrst_hs_data", hs_data_o, 8'h00);
        cs_ni  = 1'b1;
        sck_i  = 1'b0;
        mosi_i = 1'b0;
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (3) @(negedge clk_i);
        reg_rd("status_post_reset", ADDR_STATUS, 8'h05);

        // Randomized traffic against the queue model.
        for (int it = 0; it < 40; it++) begin
            k = int'($urandom_range(0, 3));
            for (int j = 0; j < k; j++) m_push_tx(8'($urandom));
            n = int'($urandom_range(1, 3));
            for (int b = 0; b < n; b++) mo[b] = 8'($urandom);
            spi_frame(n);
            // One TX load at frame start plus one after each completed byte.
            for (int b = 0; b <= n; b++) begin
                if (m_tx.size() != 0) e = m_tx.pop_front();
                else e = 8'hFF;
                if (b < n) check($sformatf("rnd%0d_miso%0d", it, b), mi[b], e);
            end
            for (int b = 0; b < n; b++) begin
                if (m_rx.size() < DEPTH) m_rx.push_back(mo[b]);
                else m_rx_ovr = 1'b1;
            end
            k = int'($urandom_range(0, 4));
            for (int j = 0; j < k; j++) m_read_rx($sformatf("rnd%0d_rx%0d", it, j));
            reg_rd($sformatf("rnd%0d_status", it), ADDR_STATUS, m_status());
            if ($urandom_range(0, 7) == 0) begin
                reg_wr(ADDR_STATUS, 8'h30);
                m_rx_ovr = 1'b0;
                m_tx_ovf = 1'b0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
